bram_tdp_bist: RTL
==================

BRAM_TDP_BIST -- requirements
Module: bram_tdp_bist

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: BRAM address width; H = 2^(ADDR_WIDTH-1) words per port half.
REQ-002 SHALL have parameter DATA_WIDTH, default 36: BRAM data width.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge; the BRAM clk_a and clk_b are tied to it externally.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to run the test; ignored unless idle.
REQ-006 SHALL have port inv, input, 1: inverted-pattern select, sampled with start.
REQ-007 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
REQ-008 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port pass, output, 1: result flag, held until the next accepted start.
REQ-010 SHALL have port err_cnt, output, 16: mismatch count, saturating at 16'hFFFF.
REQ-011 SHALL have port fail_addr, output, ADDR_WIDTH: address of the first mismatch.
REQ-012 SHALL have ports rce_a/rce_b (output, 1), ra_a/ra_b (output, ADDR_WIDTH), rq_a/rq_b (input, DATA_WIDTH), wce_a/wce_b (output, 1), wa_a/wa_b (output, ADDR_WIDTH) and wd_a/wd_b (output, DATA_WIDTH), connecting to the BRAM TDP ports.

Function
REQ-013 The pattern SHALL be pat(x) = (x | x<<20 | 20'h55000), computed at width max(DATA_WIDTH, ADDR_WIDTH+20), truncated to DATA_WIDTH, and bitwise inverted when the latched inv=1.
REQ-014 The FSM SHALL have states IDLE, WRITE, READ, DRAIN and DONE, all registered.
REQ-015 IDLE SHALL go to WRITE when start=1; on this transition err_cnt, fail_addr and pass clear to 0, inv is latched and the counter k is set to 0.
REQ-016 In WRITE (k=0..H-1): wce_a=1, wa_a=k, wd_a=pat(k); wce_b=1, wa_b=H+k, wd_b=pat(H+k); after k=H-1, go to READ with k=0.
REQ-017 In READ (k=0..H-1): rce_a=1, ra_a=k; rce_b=1, ra_b=H+k; write strobes are 0; after k=H-1, go to DRAIN.
REQ-018 Read latency SHALL be 1 cycle: rq_x is compared to the pat() of the address issued in the previous cycle, using a valid and expected pipeline stage per port.
REQ-019 DRAIN SHALL last one cycle and perform the final compare; DONE SHALL last one cycle and assert done=1 and pass=(err_cnt==0), then return to IDLE.
REQ-020 Timing: start sampled at cycle 0, writes at cycles 1..H, reads at cycles H+1..2H, drain at 2H+1, done at 2H+2.
REQ-021 Each mismatching compare SHALL increment err_cnt by 1 (by 2 if both ports mismatch in the same cycle), saturating at 16'hFFFF.
REQ-022 fail_addr SHALL latch only on the first mismatch of a run; if both ports fail in that cycle, the port A address wins.
REQ-023 A start received while busy=1 SHALL be ignored with no effect.
REQ-024 Outside WRITE all wce_x SHALL be 0; outside READ all rce_x SHALL be 0; address and data outputs SHALL be 0 when their strobe is low.

Reset
REQ-025 When rst_n=0 at a clock edge: the FSM goes to IDLE, and busy, done, pass, all strobes, addresses, wd_x, err_cnt, fail_addr, k and the pipeline valids become 0.
REQ-026 Reset mid-run SHALL abort the run without producing a done pulse; all strobes SHALL be low in the first cycle after the edge.

Structure
REQ-027 Package bram_tdp_bist_pkg SHALL hold the state enum and the pat() function.
REQ-028 Sub-module bram_tdp_bist_checker (the compare stage and per-port mismatch flag and address) SHALL be instantiated once per port.

Verification
Bench configuration: ADDR_WIDTH=10, DATA_WIDTH=36, H=512, with a behavioural TDP model of 1-cycle latency.
REQ-029 Fault-free model, start with inv=0 -> done at cycle 1026, pass=1, err_cnt=0.
REQ-030 Pattern check -> write cycle k=3: wd_a=36'h000355003; k=0: wa_b=0x200, wd_b=36'h020055200; with inv=1, wd_a at k=3 is 36'hFFFCAAFFC.
REQ-031 Model forces bit 0 of address 0x205 to 0 -> err_cnt=1, fail_addr=0x205, pass=0.
REQ-032 Faults at 0x005 and 0x205, hit in the same read cycle -> err_cnt=2, fail_addr=0x005.
REQ-033 start pulsed again at cycle 300 -> ignored, done still at cycle 1026; rst_n=0 at cycle 100 -> strobes and busy 0 at cycle 101, no done pulse, next start runs cleanly.

Source files
------------

// File: rtl/bram_tdp_bist_pkg.sv
// Shared types and the test pattern generator
// for the BRAM true-dual-port BIST.
package bram_tdp_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_e;

   // Wide enough for DATA_WIDTH and ADDR_WIDTH+20 up to 64 bits.
   localparam int PAT_W = 64;

   function automatic logic [PAT_W-1:0] pat(
      input logic [PAT_W-1:0] x,
      input logic             iv
   );
      logic [PAT_W-1:0] p;
      p = x | (x << 20) | PAT_W'(20'h55000);
      return iv ? ~p : p;
   endfunction

endpackage

// File: rtl/bram_tdp_bist_if.sv
// Strobe, address and data bundle between the
// BIST engine and both ports of a TDP BRAM.
interface bram_tdp_bist_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 36
);
   logic                  rce_a;
   logic                  rce_b;
   logic [ADDR_WIDTH-1:0] ra_a;
   logic [ADDR_WIDTH-1:0] ra_b;
   logic [DATA_WIDTH-1:0] rq_a;
   logic [DATA_WIDTH-1:0] rq_b;
   logic                  wce_a;
   logic                  wce_b;
   logic [ADDR_WIDTH-1:0] wa_a;
   logic [ADDR_WIDTH-1:0] wa_b;
   logic [DATA_WIDTH-1:0] wd_a;
   logic [DATA_WIDTH-1:0] wd_b;

   modport master (
      output rce_a, rce_b, ra_a, ra_b,
      output wce_a, wce_b, wa_a, wa_b,
      output wd_a, wd_b,
      input  rq_a, rq_b
   );

   modport slave (
      input  rce_a, rce_b, ra_a, ra_b,
      input  wce_a, wce_b, wa_a, wa_b,
      input  wd_a, wd_b,
      output rq_a, rq_b
   );
endinterface

// File: rtl/bram_tdp_bist_checker.sv
// One-cycle compare stage for a single BRAM port:
// holds the expected word for the read issued last cycle.
module bram_tdp_bist_checker
   import bram_tdp_bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 36
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  vld_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  inv_i,
   input  logic [DATA_WIDTH-1:0] rq_i,
   output logic                  mis_o,
   output logic [ADDR_WIDTH-1:0] addr_o
);

   logic                  vld_q, vld_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;

   always_comb begin
      vld_d  = vld_i & ~clr;
      exp_d  = '0;
      addr_d = '0;
      if (vld_i) begin
         exp_d  = DATA_WIDTH'(pat(PAT_W'(addr_i), inv_i));
         addr_d = addr_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         exp_q  <= '0;
         addr_q <= '0;
      end else begin
         vld_q  <= vld_d;
         exp_q  <= exp_d;
         addr_q <= addr_d;
      end
   end

   assign mis_o  = vld_q && (rq_i != exp_q);
   assign addr_o = addr_q;

endmodule

// File: rtl/bram_tdp_bist.sv
// BIST engine: port A covers the lower half, port B
// the upper half; write both halves, then read back.
module bram_tdp_bist
   import bram_tdp_bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 36
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  inv,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_cnt,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   bram_tdp_bist_if.master       mem
);

   localparam int KW = ADDR_WIDTH - 1;
   localparam logic [KW-1:0] K_LAST = '1;

   state_e                state_q, state_d;
   logic [KW-1:0]         k_q, k_d;
   logic                  inv_q, inv_d;
   logic                  pass_q, pass_d;
   logic [15:0]           err_q, err_d;
   logic [ADDR_WIDTH-1:0] fa_q, fa_d;

   logic [ADDR_WIDTH-1:0] addr_a, addr_b;
   logic [ADDR_WIDTH-1:0] mis_addr_a, mis_addr_b;
   logic                  mis_a, mis_b, clr;
   logic [16:0]           sum;

   assign addr_a = {1'b0, k_q};
   assign addr_b = {1'b1, k_q};
   assign clr    = (state_q == IDLE) && start;

   always_comb begin
      mem.wce_a = 1'b0;
      mem.wa_a  = '0;
      mem.wd_a  = '0;
      mem.wce_b = 1'b0;
      mem.wa_b  = '0;
      mem.wd_b  = '0;
      mem.rce_a = 1'b0;
      mem.ra_a  = '0;
      mem.rce_b = 1'b0;
      mem.ra_b  = '0;
      unique case (state_q)
         WRITE: begin
            mem.wce_a = 1'b1;
            mem.wa_a  = addr_a;
            mem.wd_a  = DATA_WIDTH'(pat(PAT_W'(addr_a), inv_q));
            mem.wce_b = 1'b1;
            mem.wa_b  = addr_b;
            mem.wd_b  = DATA_WIDTH'(pat(PAT_W'(addr_b), inv_q));
         end
         READ: begin
            mem.rce_a = 1'b1;
            mem.ra_a  = addr_a;
            mem.rce_b = 1'b1;
            mem.ra_b  = addr_b;
         end
         default: ;
      endcase
   end

   bram_tdp_bist_checker #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_chk_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .vld_i  (mem.rce_a),
      .addr_i (mem.ra_a),
      .inv_i  (inv_q),
      .rq_i   (mem.rq_a),
      .mis_o  (mis_a),
      .addr_o (mis_addr_a)
   );

   bram_tdp_bist_checker #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_chk_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .vld_i  (mem.rce_b),
      .addr_i (mem.ra_b),
      .inv_i  (inv_q),
      .rq_i   (mem.rq_b),
      .mis_o  (mis_b),
      .addr_o (mis_addr_b)
   );

   assign sum = {1'b0, err_q} + 17'(mis_a) + 17'(mis_b);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      inv_d   = inv_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fa_d    = fa_q;
      // Saturated counter never returns to 0, so 0 marks "no miss yet".
      if (mis_a || mis_b) begin
         err_d = sum[16] ? 16'hFFFF : sum[15:0];
         if (err_q == 16'd0)
            fa_d = mis_a ? mis_addr_a : mis_addr_b;
      end
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WRITE;
               k_d     = '0;
               inv_d   = inv;
               pass_d  = 1'b0;
               err_d   = '0;
               fa_d    = '0;
            end
         end
         WRITE: begin
            if (k_q == K_LAST) begin
               state_d = READ;
               k_d     = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         READ: begin
            if (k_q == K_LAST) begin
               state_d = DRAIN;
               k_d     = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DRAIN: begin
            state_d = DONE;
            pass_d  = (err_d == 16'd0);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         inv_q   <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fa_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         inv_q   <= inv_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fa_q    <= fa_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign pass      = pass_q;
   assign err_cnt   = err_q;
   assign fail_addr = fa_q;

endmodule
